mimo_layer_merge: RTL
=====================

Name: mimo_layer_merge

Overview:
- Downstream of the 4-layer MIMO receive path; consumes the four parallel demapped byte streams (8-bit byte plus valid per layer, no input backpressure).
- Buffers each layer in its own FIFO and emits one layer-interleaved byte stream in strict order: layer 0, 1, ..., n_layers-1, 0, ...
- Output uses a valid/ready handshake.
- Drives an almost-full flow-control flag back toward the front end.
- Flags per-layer overflow.

Parameters:
- DEPTH, 16, entries per layer FIFO (power of two, >=4).
- AFULL_MARGIN, 4, in_ready drops when any active FIFO count >= DEPTH-AFULL_MARGIN.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear pulse (driven by mode/config update).
- n_layers  in  2  active layers minus one (0 means 1 layer, 3 means 4 layers). Static; changes only in a cycle where flush=1.
- in_data_0..in_data_3  in  8 each  demapped byte per layer.
- in_valid_0..in_valid_3  in  1 each  byte qualifier per layer.
- m_data  out  8  merged byte.
- m_layer  out  2  source layer of m_data.
- m_valid  out  1  output byte valid.
- m_ready  in  1  downstream accept.
- in_ready  out  1  almost-full backpressure toward upstream.
- overflow  out  4  sticky per-layer drop flag.
- byte_cnt  out  16  bytes accepted on output since the last flush.

Behaviour:
- Reset (rst_n low, async): all FIFOs empty, read pointer ptr=0, m_valid=0, m_data=0, m_layer=0, overflow=0, byte_cnt=0, in_ready=1.
- Active layers are L = 0..n_layers. in_valid on an inactive layer is ignored: nothing is written and no overflow is flagged.
- Write, layer L: at the edge where in_valid_L=1, push in_data_L if count_L < DEPTH, or if layer L is popped in the same cycle (a same-cycle pop frees the slot).
- Drop: if the write condition fails, discard the byte and set overflow[L]=1. overflow[L] stays set until flush.
- Pop condition: FIFO[ptr] is non-empty AND (m_valid=0 OR m_ready=1).
- On a pop:
  - m_data <= head of FIFO[ptr]; m_layer <= ptr; m_valid <= 1.
  - ptr <= (ptr == n_layers) ? 0 : ptr+1.
- Strict ordering: if FIFO[ptr] is empty, no pop occurs and ptr holds, even when other layers have data. Other layers are never skipped.
- If m_valid=1 and m_ready=1 but no pop is possible, m_valid <= 0.
- If m_valid=1 and m_ready=0, m_data, m_layer and m_valid hold stable.
- Latency: a byte written at edge k onto an empty path, with ptr already at that layer, shows m_valid=1 after edge k+1. Throughput is 1 byte/cycle while data is available.
- byte_cnt increments on every cycle with m_valid and m_ready both high; wraps at 2^16.
- in_ready is combinational from registered counts: 0 when any active layer's count >= DEPTH-AFULL_MARGIN, else 1. Inactive layers never affect in_ready.
- flush (highest priority, synchronous):
  - FIFOs emptied; ptr=0; m_valid=0 (a pending unaccepted byte is discarded); overflow=0; byte_cnt=0.
  - Bytes presented in the flush cycle are discarded and do not set overflow.
- Simultaneous push and pop on the same FIFO in one cycle: count unchanged, both operations take effect.
- Pointer arithmetic: FIFO indices are log2(DEPTH) bits and wrap naturally. Counts are log2(DEPTH)+1 bits.

Test Plan:
- Ordering, 4 layers: n_layers=3, all four layers valid in one cycle with bytes 0x10, 0x20, 0x30, 0x40, m_ready=1 -> m_data 0x10, 0x20, 0x30, 0x40 on 4 consecutive cycles; m_layer 0, 1, 2, 3; byte_cnt=4.
- Strict stall: only layer 0 and layer 2 fed (0xA0, 0xA2) -> 0xA0 out, then ptr=1 stalls with m_valid=0 and 0xA2 held. Feeding layer 1 with 0xA1 then yields 0xA1 followed by 0xA2.
- Backpressure: m_ready=0 with m_valid=1 for 10 cycles -> m_data stable. With DEPTH=16 and AFULL_MARGIN=4, in_ready falls when the 12th byte is buffered in a layer.
- Overflow: 17 bytes written to layer 3 with m_ready=0 -> 17th byte dropped, overflow=4'b1000. A subsequent flush clears overflow, byte_cnt, and m_valid.
- Reduced layers: n_layers=1, bytes on layers 0-3 -> output alternates layer 0/1 only; layer 2/3 input ignored; overflow stays 0.
- Async reset mid-stream: rst_n asserted while m_valid=1 and FIFOs half full -> outputs return immediately to reset values. After release, the first new byte from layer 0 appears 1 cycle after its write.

Source files
------------

// File: rtl/mimo_layer_merge.sv
// mimo_layer_merge: buffers up to four demapped byte streams in per-layer FIFOs and
// emits them as one layer-interleaved stream in strict round-robin order
// (layer 0, 1, ..., n_layers, 0, ...). Never skips a layer whose FIFO is empty.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   flush                    synchronous clear (FIFOs, pointer, output, flags, counter)
//   n_layers[1:0]            active layers minus one; changes only with flush
//   in_data_k[7:0], in_valid_k  per-layer byte input, no backpressure (k = 0..3)
//   m_data[7:0], m_layer[1:0], m_valid, m_ready   merged output, valid/ready
//   in_ready                 almost-full flag toward the front end
//   overflow[3:0]            sticky per-layer drop flags
//   byte_cnt[15:0]           output bytes accepted since the last flush
`timescale 1ns / 1ps

module mimo_layer_merge #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned AFULL_MARGIN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic [1:0] n_layers,
    input  logic [7:0] in_data_0,
    input  logic [7:0] in_data_1,
    input  logic [7:0] in_data_2,
    input  logic [7:0] in_data_3,
    input  logic       in_valid_0,
    input  logic       in_valid_1,
    input  logic       in_valid_2,
    input  logic       in_valid_3,
    output logic [7:0] m_data,
    output logic [1:0] m_layer,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       in_ready,
    output logic [3:0] overflow,
    output logic [15:0] byte_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FullCnt  = CW'(DEPTH);
    localparam logic [CW-1:0] AfullCnt = CW'(DEPTH - AFULL_MARGIN);

    logic [7:0]    in_data [4];
    logic [3:0]    in_valid;
    logic [3:0]    active;

    logic [7:0]    mem_q [4][DEPTH];
    logic [AW-1:0] wr_ptr_q [4];
    logic [AW-1:0] wr_ptr_d [4];
    logic [AW-1:0] rd_ptr_q [4];
    logic [AW-1:0] rd_ptr_d [4];
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];

    logic [1:0]    ptr_q, ptr_d;
    logic          m_valid_q, m_valid_d;
    logic [7:0]    m_data_q, m_data_d;
    logic [1:0]    m_layer_q, m_layer_d;
    logic [3:0]    overflow_q, overflow_d;
    logic [15:0]   byte_cnt_q, byte_cnt_d;

    logic          pop;
    logic [3:0]    pop_l;
    logic [3:0]    push_l;
    logic [3:0]    drop_l;
    logic [7:0]    head;

    // Input gathering and active-layer mask
    always_comb begin
        in_data[0] = in_data_0;
        in_data[1] = in_data_1;
        in_data[2] = in_data_2;
        in_data[3] = in_data_3;
        in_valid   = {in_valid_3, in_valid_2, in_valid_1, in_valid_0};
        unique case (n_layers)
            2'd0:    active = 4'b0001;
            2'd1:    active = 4'b0011;
            2'd2:    active = 4'b0111;
            default: active = 4'b1111;
        endcase
    end

    // Push/pop decisions; flush suppresses both so bytes in that cycle are discarded.
    always_comb begin
        pop   = !flush && (cnt_q[ptr_q] != '0) && (!m_valid_q || m_ready);
        pop_l = pop ? (4'b0001 << ptr_q) : 4'b0000;
        head  = mem_q[ptr_q][rd_ptr_q[ptr_q]];
        for (int l = 0; l < 4; l++) begin
            // A same-cycle pop on a full FIFO frees the slot being written.
            push_l[l] = !flush && active[l] && in_valid[l] &&
                        ((cnt_q[l] < FullCnt) || pop_l[l]);
            drop_l[l] = !flush && active[l] && in_valid[l] && !push_l[l];
        end
    end

    // Next-state logic
    always_comb begin
        for (int l = 0; l < 4; l++) begin
            wr_ptr_d[l] = wr_ptr_q[l] + AW'(push_l[l]);
            rd_ptr_d[l] = rd_ptr_q[l] + AW'(pop_l[l]);
            cnt_d[l]    = cnt_q[l] + CW'(push_l[l]) - CW'(pop_l[l]);
        end
        ptr_d      = ptr_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_layer_d  = m_layer_q;
        overflow_d = overflow_q | drop_l;
        byte_cnt_d = byte_cnt_q + 16'(m_valid_q && m_ready);

        if (pop) begin
            m_data_d  = head;
            m_layer_d = ptr_q;
            m_valid_d = 1'b1;
            ptr_d     = (ptr_q == n_layers) ? 2'd0 : ptr_q + 2'd1;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end

        if (flush) begin
            for (int l = 0; l < 4; l++) begin
                wr_ptr_d[l] = '0;
                rd_ptr_d[l] = '0;
                cnt_d[l]    = '0;
            end
            ptr_d      = 2'd0;
            m_valid_d  = 1'b0;
            overflow_d = 4'b0000;
            byte_cnt_d = 16'd0;
        end
    end

    // Almost-full: only active layers count.
    always_comb begin
        in_ready = 1'b1;
        for (int l = 0; l < 4; l++) begin
            if (active[l] && (cnt_q[l] >= AfullCnt)) begin
                in_ready = 1'b0;
            end
        end
    end

    // Storage needs no reset; validity is tracked by the counts.
    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (push_l[l]) begin
                mem_q[l][wr_ptr_q[l]] <= in_data[l];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < 4; l++) begin
                wr_ptr_q[l] <= '0;
                rd_ptr_q[l] <= '0;
                cnt_q[l]    <= '0;
            end
            ptr_q      <= 2'd0;
            m_valid_q  <= 1'b0;
            m_data_q   <= 8'd0;
            m_layer_q  <= 2'd0;
            overflow_q <= 4'b0000;
            byte_cnt_q <= 16'd0;
        end else begin
            for (int l = 0; l < 4; l++) begin
                wr_ptr_q[l] <= wr_ptr_d[l];
                rd_ptr_q[l] <= rd_ptr_d[l];
                cnt_q[l]    <= cnt_d[l];
            end
            ptr_q      <= ptr_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_layer_q  <= m_layer_d;
            overflow_q <= overflow_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign m_data   = m_data_q;
    assign m_layer  = m_layer_q;
    assign m_valid  = m_valid_q;
    assign overflow = overflow_q;
    assign byte_cnt = byte_cnt_q;

endmodule
